// File: rtl/sav_backup_ctrl.sv
// Save-RAM backup controller: moves battery-backed RAM between the SD image and NVRAM
// in 512-byte sectors, with length clamping, queued requests, autosave and download abort.
module sav_backup_ctrl #(
  parameter int unsigned SECTOR_BITS     = 4,
  parameter logic [23:0] AUTOSAVE_CYCLES = 24'd0
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   img_mounted,
  input  logic [31:0]            img_size,
  input  logic                   download,
  input  logic                   save_req,
  input  logic                   nvram_we,
  output logic [31:0]            sd_lba,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  input  logic [8:0]             sd_buff_addr,
  input  logic                   sd_buff_wr,
  output logic [SECTOR_BITS+8:0] buf_addr,
  output logic                   buf_we,
  output logic                   ena,
  output logic                   busy,
  output logic                   dirty,
  output logic                   core_reset
);

  typedef enum logic [1:0] {StIdle, StReq, StXfer} state_e;

  localparam logic [SECTOR_BITS-1:0] LbaOne     = SECTOR_BITS'(1);
  localparam logic [SECTOR_BITS-1:0] LbaMax     = '1;
  localparam logic [32:0]            MaxSectors = 33'd1 << SECTOR_BITS;
  localparam logic [23:0]            IdleMax    = '1;

  state_e                 state_q, state_d;
  logic                   img_mounted_q, download_q, save_req_q, ack_q;
  logic                   ena_q, ena_d;
  logic [SECTOR_BITS-1:0] last_q, last_d;
  logic [SECTOR_BITS-1:0] lba_q, lba_d;
  logic                   load_pend_q, load_pend_d;
  logic                   save_pend_q, save_pend_d;
  logic                   dirty_q, dirty_d;
  logic                   is_load_q, is_load_d;
  logic                   abort_q, abort_d;
  logic                   we_seen_q, we_seen_d;
  logic                   core_reset_q, core_reset_d;
  logic [23:0]            idle_cnt_q, idle_cnt_d;

  logic        mount_edge, download_edge, save_edge, autosave_hit;
  logic [32:0] n_sectors;

  assign mount_edge    = img_mounted & ~img_mounted_q;
  assign download_edge = download & ~download_q;
  assign save_edge     = save_req & ~save_req_q;
  // 33-bit sum so a size near 4 GiB cannot wrap before the divide.
  assign n_sectors     = ({1'b0, img_size} + 33'd511) >> 9;
  assign autosave_hit  = (AUTOSAVE_CYCLES != 24'd0) && dirty_q && ena_q &&
                         (state_q == StIdle) && (idle_cnt_q == AUTOSAVE_CYCLES);

  always_comb begin
    state_d      = state_q;
    ena_d        = ena_q;
    last_d       = last_q;
    lba_d        = lba_q;
    load_pend_d  = load_pend_q;
    save_pend_d  = save_pend_q;
    dirty_d      = dirty_q;
    is_load_d    = is_load_q;
    abort_d      = abort_q;
    we_seen_d    = we_seen_q;
    core_reset_d = 1'b0;
    idle_cnt_d   = idle_cnt_q;

    if (mount_edge) begin
      if (img_size != 32'd0) begin
        ena_d       = 1'b1;
        last_d      = (n_sectors > MaxSectors) ? LbaMax :
                      (n_sectors[SECTOR_BITS-1:0] - LbaOne);
        load_pend_d = 1'b1;
      end else begin
        ena_d = 1'b0;
      end
    end

    // ena_d so a save edge coinciding with the first mount is still accepted.
    if ((save_edge || autosave_hit) && ena_d) begin
      save_pend_d = 1'b1;
    end

    if (download_edge) begin
      ena_d       = 1'b0;
      load_pend_d = 1'b0;
      save_pend_d = 1'b0;
      if (state_q != StIdle) begin
        abort_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (load_pend_d) begin
          state_d     = StReq;
          is_load_d   = 1'b1;
          load_pend_d = 1'b0;
          lba_d       = '0;
          we_seen_d   = 1'b0;
        end else if (save_pend_d) begin
          state_d     = StReq;
          is_load_d   = 1'b0;
          save_pend_d = 1'b0;
          lba_d       = '0;
          we_seen_d   = 1'b0;
        end
      end
      StReq: begin
        if (sd_ack) begin
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (ack_q && !sd_ack) begin
          if ((lba_q == last_q) || abort_d) begin
            state_d = StIdle;
            if (!abort_d) begin
              if (is_load_q) begin
                core_reset_d = 1'b1;
                dirty_d      = 1'b0;
              end else begin
                // A write to NVRAM during the save may not be in the image.
                dirty_d = we_seen_q;
              end
            end
          end else begin
            lba_d   = lba_q + LbaOne;
            state_d = StReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle) begin
      abort_d = 1'b0;
    end

    if (nvram_we) begin
      dirty_d   = 1'b1;
      we_seen_d = 1'b1;
    end
    if (download_edge) begin
      dirty_d = 1'b0;
    end

    if (nvram_we || (state_d != StIdle)) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IdleMax) begin
      idle_cnt_d = idle_cnt_q + 24'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= StIdle;
      img_mounted_q <= 1'b0;
      download_q    <= 1'b0;
      save_req_q    <= 1'b0;
      ack_q         <= 1'b0;
      ena_q         <= 1'b0;
      last_q        <= LbaMax;
      lba_q         <= '0;
      load_pend_q   <= 1'b0;
      save_pend_q   <= 1'b0;
      dirty_q       <= 1'b0;
      is_load_q     <= 1'b0;
      abort_q       <= 1'b0;
      we_seen_q     <= 1'b0;
      core_reset_q  <= 1'b0;
      idle_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      img_mounted_q <= img_mounted;
      download_q    <= download;
      save_req_q    <= save_req;
      ack_q         <= sd_ack;
      ena_q         <= ena_d;
      last_q        <= last_d;
      lba_q         <= lba_d;
      load_pend_q   <= load_pend_d;
      save_pend_q   <= save_pend_d;
      dirty_q       <= dirty_d;
      is_load_q     <= is_load_d;
      abort_q       <= abort_d;
      we_seen_q     <= we_seen_d;
      core_reset_q  <= core_reset_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  assign sd_lba     = {{(32 - SECTOR_BITS){1'b0}}, lba_q};
  assign sd_rd      = (state_q == StReq) && is_load_q;
  assign sd_wr      = (state_q == StReq) && !is_load_q;
  assign busy       = (state_q != StIdle);
  assign buf_addr   = {lba_q, sd_buff_addr};
  assign buf_we     = sd_buff_wr && sd_ack && busy && is_load_q;
  assign ena        = ena_q;
  assign dirty      = dirty_q;
  assign core_reset = core_reset_q;

endmodule

// File: tb/tb_sav_backup_ctrl.sv
// Scoreboard bench for sav_backup_ctrl: a sector-level model queues the expected SD requests
// and core resets; a negedge monitor compares them as the DUT presents them.
module tb_sav_backup_ctrl;

  localparam int unsigned SB   = 4;
  localparam logic [23:0] AUTO = 24'd100;

  logic          clk_sys, reset;
  logic          img_mounted, download, save_req, nvram_we;
  logic [31:0]   img_size;
  logic [31:0]   sd_lba;
  logic          sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [8:0]    sd_buff_addr;
  logic [SB+8:0] buf_addr;
  logic          buf_we, ena, busy, dirty, core_reset;

  sav_backup_ctrl #(.SECTOR_BITS(SB), .AUTOSAVE_CYCLES(AUTO)) dut (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_size(img_size),
    .download(download), .save_req(save_req), .nvram_we(nvram_we), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
    .sd_buff_wr(sd_buff_wr), .buf_addr(buf_addr), .buf_we(buf_we), .ena(ena), .busy(busy),
    .dirty(dirty), .core_reset(core_reset)
  );

  typedef struct packed {
    logic [1:0]  kind;  // 0 read, 1 write, 2 core_reset
    logic [31:0] lba;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  fall_cyc = -10, last_cr_cyc = -10, last_w0_cyc = -10;

  // Sector-level model state.
  int unsigned m_nsec = 16;
  bit          m_ena = 0, m_dirty = 0;

  initial begin
    clk_sys = 0;
    forever #5 clk_sys = ~clk_sys;
  end

  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic model_mount(input int unsigned size);
    longint unsigned n;
    if (size == 0) begin
      m_ena = 0;
      return;
    end
    m_ena = 1;
    n = (longint'(size) + 511) / 512;
    if (n > 16) n = 16;
    m_nsec = int'(n);
    for (int i = 0; i < m_nsec; i++) exp_q.push_back('{kind: 2'd0, lba: i});
    exp_q.push_back('{kind: 2'd2, lba: 0});
    m_dirty = 0;
  endtask

  task automatic model_save(input int unsigned cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back('{kind: 2'd1, lba: i});
  endtask

  task automatic sb_compare(input ev_t got);
    ev_t want;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected: got kind=%0d lba=%0d want none", got.kind, got.lba);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        failures++;
        $display("FAIL sb_event: got kind=%0d lba=%0d want kind=%0d lba=%0d",
                 got.kind, got.lba, want.kind, want.lba);
      end
    end
  endtask

  // SD responder: random latency and sector length.
  initial begin
    sd_ack = 0;
    sd_buff_wr = 0;
    sd_buff_addr = 0;
    forever begin
      tick();
      if (!reset && (sd_rd || sd_wr)) begin
        automatic bit rd  = sd_rd;
        automatic int len = $urandom_range(2, 5);
        repeat ($urandom_range(0, 3)) tick();
        if (!reset) begin
          sd_ack = 1;
          for (int k = 0; k < len; k++) begin
            sd_buff_addr = 9'($urandom_range(0, 511));
            sd_buff_wr   = rd && ($urandom_range(0, 1) == 1);
            tick();
            if (reset) break;
          end
          sd_ack = 0;
          sd_buff_wr = 0;
          sd_buff_addr = 0;
        end
      end
    end
  end

  // Monitor.
  initial begin
    bit             req_prev = 0, ack_prev = 0, cur_rd = 0;
    logic [SB-1:0]  cur_lba = '0;
    ev_t            ev;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        req_prev = 0;
        ack_prev = 0;
      end else begin
        if ((sd_rd || sd_wr) && !req_prev) begin
          ev.kind = sd_wr ? 2'd1 : 2'd0;
          ev.lba  = sd_lba;
          cur_rd  = sd_rd;
          cur_lba = sd_lba[SB-1:0];
          chk("lba_high_bits", 64'(sd_lba[31:SB]), 64'd0);
          if (sd_lba != 0) chk("next_req_latency", 64'(cyc), 64'(fall_cyc + 1));
          else if (sd_wr) last_w0_cyc = cyc;
          sb_compare(ev);
        end
        if (core_reset) begin
          ev.kind = 2'd2;
          ev.lba  = 0;
          chk("core_reset_latency", 64'(cyc), 64'(fall_cyc + 1));
          last_cr_cyc = cyc;
          sb_compare(ev);
        end
        if (ack_prev && !sd_ack) fall_cyc = cyc;
        chk("buf_we", 64'(buf_we), 64'(sd_buff_wr && sd_ack && cur_rd));
        if (sd_ack) chk("buf_addr", 64'(buf_addr), 64'({cur_lba, sd_buff_addr}));
        req_prev = sd_rd || sd_wr;
        ack_prev = sd_ack;
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!(exp_q.size() == 0 && !busy) && n < 3000);
    chk(name, 64'(n >= 3000), 64'd0);
  endtask

  task automatic wait_req(input string name, input bit wr, input int unsigned lba);
    int n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!((wr ? sd_wr : sd_rd) && sd_lba == lba) && n < 3000);
    chk(name, 64'(n >= 3000), 64'd0);
  endtask

  task automatic do_mount(input logic [31:0] size, input bit with_save);
    tick();
    img_size = size;
    img_mounted = 1;
    if (with_save) save_req = 1;
    tick();
    tick();
    img_mounted = 0;
    save_req = 0;
  endtask

  task automatic do_save();
    tick();
    save_req = 1;
    tick();
    tick();
    save_req = 0;
  endtask

  task automatic do_we();
    tick();
    nvram_we = 1;
    tick();
    nvram_we = 0;
  endtask

  initial begin
    int c0;
    int unsigned sz;
    reset = 1;
    img_mounted = 0;
    img_size = 0;
    download = 0;
    save_req = 0;
    nvram_we = 0;
    repeat (3) tick();
    reset = 0;
    @(negedge clk_sys);
    chk("rst_sd_rd", 64'(sd_rd), 0);
    chk("rst_sd_wr", 64'(sd_wr), 0);
    chk("rst_sd_lba", 64'(sd_lba), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ena", 64'(ena), 0);
    chk("rst_dirty", 64'(dirty), 0);
    chk("rst_core_reset", 64'(core_reset), 0);
    chk("rst_buf_addr", 64'(buf_addr), 0);

    // Full 8 KiB load.
    model_mount(8192);
    do_mount(8192, 0);
    wait_idle("load8k_done");
    chk("load8k_ena", 64'(ena), 64'(m_ena));
    chk("load8k_dirty", 64'(dirty), 64'(m_dirty));

    // Short image clamps both load and save.
    model_mount(1000);
    do_mount(1000, 0);
    wait_idle("load1000_done");
    model_save(m_nsec);
    do_save();
    wait_idle("save1000_done");
    chk("save1000_dirty", 64'(dirty), 0);

    // Random sizes; first one mounts and saves in the same cycle.
    for (int it = 0; it < 3; it++) begin
      sz = $urandom_range(1, 20000);
      model_mount(sz);
      if (it == 0) model_save(m_nsec);
      do_mount(sz, it == 0);
      wait_idle("rand_mount_done");
      chk("rand_mount_ena", 64'(ena), 64'(m_ena));
    end

    // Autosave after idle period.
    model_mount(8192);
    do_mount(8192, 0);
    wait_idle("auto_load_done");
    model_save(m_nsec);
    tick();
    nvram_we = 1;
    c0 = cyc;
    tick();
    nvram_we = 0;
    wait_idle("autosave_done");
    chk("autosave_start_lo", 64'(last_w0_cyc - c0 >= 101), 1);
    chk("autosave_start_hi", 64'(last_w0_cyc - c0 <= 102), 1);
    chk("autosave_dirty_clear", 64'(dirty), 0);
    model_save(m_nsec);
    do_we();
    wait_req("autosave2_start", 1, 0);
    do_we();
    wait_idle("autosave2_done");
    chk("we_during_save_dirty", 64'(dirty), 1);
    model_save(m_nsec);
    wait_idle("autosave3_done");
    chk("autosave3_dirty", 64'(dirty), 0);

    // Save requested during a load; second request absorbed.
    model_mount(8192);
    do_mount(8192, 0);
    wait_req("load_at5", 0, 5);
    model_save(m_nsec);
    do_save();
    wait_req("load_at8", 0, 8);
    do_save();
    wait_idle("queued_save_done");
    chk("queued_save_gap", 64'(last_w0_cyc), 64'(last_cr_cyc + 1));

    // Download aborts a save at sector 3.
    model_save(4);
    do_save();
    wait_req("save_at3", 1, 3);
    tick();
    download = 1;
    m_ena = 0;
    m_dirty = 0;
    tick();
    tick();
    download = 0;
    wait_idle("abort_done");
    repeat (60) @(negedge clk_sys);
    chk("abort_ena", 64'(ena), 64'(m_ena));
    chk("abort_busy", 64'(busy), 0);
    chk("abort_dirty", 64'(dirty), 64'(m_dirty));

    // Zero-size mount: disabled, nothing queued.
    model_mount(8192);
    do_mount(8192, 0);
    wait_idle("remount_done");
    model_mount(0);
    do_mount(0, 0);
    repeat (30) @(negedge clk_sys);
    chk("zero_mount_ena", 64'(ena), 64'(m_ena));
    chk("zero_mount_busy", 64'(busy), 0);

    // Reset mid-transfer.
    model_mount(8192);
    do_mount(8192, 0);
    wait_req("load_at2", 0, 2);
    tick();
    reset = 1;
    tick();
    @(negedge clk_sys);
    chk("midrst_sd_rd", 64'(sd_rd), 0);
    chk("midrst_sd_wr", 64'(sd_wr), 0);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_ena", 64'(ena), 0);
    exp_q.delete();
    m_ena = 0;
    repeat (2) tick();
    reset = 0;
    repeat (60) @(negedge clk_sys);
    chk("post_rst_busy", 64'(busy), 0);
    chk("post_rst_ena", 64'(ena), 64'(m_ena));

    chk("sb_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
